// File: rtl/run_sequencer_if.sv
// Run-control bus between the run sequencer and the core/testbench side.
// The slave modport is the sequencer's view; master is the controller's view.
interface run_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16,
    parameter int SEL_W = 2
);
    logic             start;
    logic [SEL_W-1:0] prog_sel;
    logic             halt;
    logic             abort;
    logic             run_en;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_value;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [7:0]       run_count;

    modport slave (
        input  start, prog_sel, halt, abort,
        output run_en, pc_load, pc_load_value, ack, timeout, cycle_count, run_count
    );

    modport master (
        output start, prog_sel, halt, abort,
        input  run_en, pc_load, pc_load_value, ack, timeout, cycle_count, run_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Run-control FSM for the 9-bit-ISA core: start/run/ack handshake,
// program-entry selection and a cycle-count watchdog. All outputs registered.
module run_sequencer #(
    parameter int PC_W           = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int NUM_PROG       = 4,
    parameter int ENTRY_STRIDE   = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    run_sequencer_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_PROG);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic             run_en;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_value;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [7:0]       run_count;

    // Entry address of program k is k*ENTRY_STRIDE, computed at PC width.
    function automatic logic [PC_W-1:0] entry_addr(input logic [SEL_W-1:0] sel);
        logic [PC_W-1:0] idx;
        idx = PC_W'(sel);
        return idx * PC_W'(ENTRY_STRIDE);
    endfunction

    // Saturating increment so a long run never wraps the cycle counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    // Run-control state machine with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sel_q         <= '0;
            run_en        <= 1'b0;
            pc_load       <= 1'b0;
            pc_load_value <= '0;
            ack           <= 1'b0;
            timeout       <= 1'b0;
            cycle_count   <= '0;
            run_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ARMED;
                        sel_q <= bus.prog_sel;
                    end
                end
                ARMED: begin
                    if (bus.start) begin
                        sel_q <= bus.prog_sel;
                    end else begin
                        // Falling edge of start launches the run; clear the
                        // counter here so LOAD already shows the fresh run.
                        state         <= LOAD;
                        pc_load       <= 1'b1;
                        pc_load_value <= entry_addr(sel_q);
                        cycle_count   <= '0;
                        ack           <= 1'b0;
                        timeout       <= 1'b0;
                    end
                end
                LOAD: begin
                    state   <= RUN;
                    pc_load <= 1'b0;
                    run_en  <= 1'b1;
                end
                RUN: begin
                    // Every RUN cycle is counted, including the one that ends it.
                    cycle_count <= sat_inc(cycle_count);
                    if (bus.abort) begin
                        state  <= IDLE;
                        run_en <= 1'b0;
                    end else if (bus.halt) begin
                        state     <= DONE;
                        run_en    <= 1'b0;
                        ack       <= 1'b1;
                        timeout   <= 1'b0;
                        run_count <= run_count + 8'd1;
                    end else if (cycle_count == WDOG_LAST) begin
                        state     <= TIMEOUT;
                        run_en    <= 1'b0;
                        ack       <= 1'b1;
                        timeout   <= 1'b1;
                        run_count <= run_count + 8'd1;
                    end
                end
                DONE, TIMEOUT: begin
                    if (bus.start) begin
                        state   <= ARMED;
                        sel_q   <= bus.prog_sel;
                        ack     <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_en  <= 1'b0;
                    pc_load <= 1'b0;
                end
            endcase
        end
    end

    assign bus.run_en        = run_en;
    assign bus.pc_load       = pc_load;
    assign bus.pc_load_value = pc_load_value;
    assign bus.ack           = ack;
    assign bus.timeout       = timeout;
    assign bus.cycle_count   = cycle_count;
    assign bus.run_count     = run_count;
endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer with default parameters.
module tb_run_sequencer;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    run_sequencer_if #(.PC_W(32), .CNT_W(16), .SEL_W(2)) bus ();

    run_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.prog_sel = 2'd0; bus.halt = 1'b0; bus.abort = 1'b0;
        step(2);
        n_cmp++; if (bus.run_en !== 1'b0) begin n_bad++; $display("FAIL reset_run_en got %b want 0", bus.run_en); end
        n_cmp++; if (bus.pc_load !== 1'b0) begin n_bad++; $display("FAIL reset_pc_load got %b want 0", bus.pc_load); end
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", bus.ack); end
        n_cmp++; if (bus.cycle_count !== 16'd0) begin n_bad++; $display("FAIL reset_cycle_count got %0d want 0", bus.cycle_count); end
        n_cmp++; if (bus.run_count !== 8'd0) begin n_bad++; $display("FAIL reset_run_count got %0d want 0", bus.run_count); end
        reset_n = 1'b1;
        step(1);
    endtask

    // Start held 3 cycles with prog_sel=2, then released.
    task automatic test_launch;
        bus.start = 1'b1; bus.prog_sel = 2'd2;
        step(3);
        n_cmp++; if (bus.pc_load !== 1'b0) begin n_bad++; $display("FAIL armed_pc_load got %b want 0", bus.pc_load); end
        bus.start = 1'b0;
        step(1);
        n_cmp++; if (bus.pc_load !== 1'b1) begin n_bad++; $display("FAIL load_pc_load got %b want 1", bus.pc_load); end
        n_cmp++; if (bus.pc_load_value !== 32'd512) begin n_bad++; $display("FAIL load_pc_value got %0d want 512", bus.pc_load_value); end
        n_cmp++; if (bus.run_en !== 1'b0) begin n_bad++; $display("FAIL load_run_en got %b want 0", bus.run_en); end
        step(1);
        n_cmp++; if (bus.pc_load !== 1'b0) begin n_bad++; $display("FAIL run_pc_load got %b want 0", bus.pc_load); end
        n_cmp++; if (bus.run_en !== 1'b1) begin n_bad++; $display("FAIL run_run_en got %b want 1", bus.run_en); end
        n_cmp++; if (bus.cycle_count !== 16'd0) begin n_bad++; $display("FAIL run_cycle_start got %0d want 0", bus.cycle_count); end
    endtask

    // Enters RUN with cycle_count=0; halt on the 10th RUN cycle.
    task automatic test_halt;
        step(9);
        n_cmp++; if (bus.run_en !== 1'b1) begin n_bad++; $display("FAIL halt_pre_run_en got %b want 1", bus.run_en); end
        n_cmp++; if (bus.cycle_count !== 16'd9) begin n_bad++; $display("FAIL halt_pre_count got %0d want 9", bus.cycle_count); end
        bus.halt = 1'b1;
        step(1);
        bus.halt = 1'b0;
        n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL halt_ack got %b want 1", bus.ack); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL halt_timeout got %b want 0", bus.timeout); end
        n_cmp++; if (bus.cycle_count !== 16'd10) begin n_bad++; $display("FAIL halt_count got %0d want 10", bus.cycle_count); end
        n_cmp++; if (bus.run_count !== 8'd1) begin n_bad++; $display("FAIL halt_run_count got %0d want 1", bus.run_count); end
        n_cmp++; if (bus.run_en !== 1'b0) begin n_bad++; $display("FAIL halt_run_en got %b want 0", bus.run_en); end
        step(3);
        n_cmp++; if (bus.ack !== 1'b1 || bus.cycle_count !== 16'd10) begin n_bad++; $display("FAIL done_hold ack=%b count=%0d want 1/10", bus.ack, bus.cycle_count); end
    endtask

    // From DONE/TIMEOUT or IDLE: launch a run with the given select; ends in first RUN cycle.
    task automatic launch(input logic [1:0] sel);
        bus.start = 1'b1; bus.prog_sel = sel;
        step(1);
        bus.start = 1'b0;
        step(2);
    endtask

    task automatic test_watchdog;
        launch(2'd0);
        step(4095);
        n_cmp++; if (bus.run_en !== 1'b1 || bus.ack !== 1'b0) begin n_bad++; $display("FAIL wdog_pre run_en=%b ack=%b want 1/0", bus.run_en, bus.ack); end
        step(1);
        n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL wdog_ack got %b want 1", bus.ack); end
        n_cmp++; if (bus.timeout !== 1'b1) begin n_bad++; $display("FAIL wdog_timeout got %b want 1", bus.timeout); end
        n_cmp++; if (bus.cycle_count !== 16'd4096) begin n_bad++; $display("FAIL wdog_count got %0d want 4096", bus.cycle_count); end
        n_cmp++; if (bus.run_count !== 8'd2) begin n_bad++; $display("FAIL wdog_run_count got %0d want 2", bus.run_count); end
        n_cmp++; if (bus.run_en !== 1'b0) begin n_bad++; $display("FAIL wdog_run_en got %b want 0", bus.run_en); end
    endtask

    task automatic test_halt_vs_wdog_and_abort;
        launch(2'd1);
        n_cmp++; if (bus.ack !== 1'b0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL rearm_flags ack=%b timeout=%b want 0/0", bus.ack, bus.timeout); end
        step(4095);
        bus.halt = 1'b1;
        step(1);
        bus.halt = 1'b0;
        n_cmp++; if (bus.ack !== 1'b1 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL tie_flags ack=%b timeout=%b want 1/0", bus.ack, bus.timeout); end
        n_cmp++; if (bus.run_count !== 8'd3) begin n_bad++; $display("FAIL tie_run_count got %0d want 3", bus.run_count); end
        launch(2'd3);
        step(5);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        n_cmp++; if (bus.run_en !== 1'b0 || bus.ack !== 1'b0) begin n_bad++; $display("FAIL abort_flags run_en=%b ack=%b want 0/0", bus.run_en, bus.ack); end
        n_cmp++; if (bus.run_count !== 8'd3) begin n_bad++; $display("FAIL abort_run_count got %0d want 3", bus.run_count); end
        n_cmp++; if (bus.cycle_count !== 16'd6) begin n_bad++; $display("FAIL abort_count got %0d want 6", bus.cycle_count); end
        step(3);
        n_cmp++; if (bus.pc_load !== 1'b0 || bus.run_en !== 1'b0) begin n_bad++; $display("FAIL abort_idle pc_load=%b run_en=%b want 0/0", bus.pc_load, bus.run_en); end
    endtask

    task automatic test_back_to_back;
        launch(2'd3);
        n_cmp++; if (bus.run_en !== 1'b1) begin n_bad++; $display("FAIL b2b_run_en got %b want 1", bus.run_en); end
        step(1);
        bus.halt = 1'b1;
        step(1);
        bus.halt = 1'b0;
        n_cmp++; if (bus.run_count !== 8'd4 || bus.cycle_count !== 16'd2) begin n_bad++; $display("FAIL b2b_done run_count=%0d count=%0d want 4/2", bus.run_count, bus.cycle_count); end
        bus.abort = 1'b1;
        step(2);
        bus.abort = 1'b0;
        n_cmp++; if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL done_abort_ignored ack got %b want 1", bus.ack); end
        bus.start = 1'b1; bus.prog_sel = 2'd1;
        step(1);
        n_cmp++; if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL armed_ack_drop got %b want 0", bus.ack); end
        bus.start = 1'b0; bus.prog_sel = 2'd0;
        step(1);
        n_cmp++; if (bus.pc_load !== 1'b1 || bus.pc_load_value !== 32'd256) begin n_bad++; $display("FAIL b2b_load pc_load=%b value=%0d want 1/256", bus.pc_load, bus.pc_load_value); end
        n_cmp++; if (bus.cycle_count !== 16'd0) begin n_bad++; $display("FAIL b2b_count_clear got %0d want 0", bus.cycle_count); end
        step(1);
        n_cmp++; if (bus.run_en !== 1'b1) begin n_bad++; $display("FAIL b2b_run got %b want 1", bus.run_en); end
    endtask

    // In RUN: start must be ignored, then asynchronous reset clears everything.
    task automatic test_async_reset;
        bus.start = 1'b1;
        step(2);
        bus.start = 1'b0;
        n_cmp++; if (bus.run_en !== 1'b1 || bus.pc_load !== 1'b0) begin n_bad++; $display("FAIL start_in_run run_en=%b pc_load=%b want 1/0", bus.run_en, bus.pc_load); end
        n_cmp++; if (bus.cycle_count !== 16'd2) begin n_bad++; $display("FAIL start_in_run_count got %0d want 2", bus.cycle_count); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.run_en !== 1'b0 || bus.ack !== 1'b0 || bus.pc_load !== 1'b0) begin n_bad++; $display("FAIL async_rst_flags run_en=%b ack=%b pc_load=%b want 0/0/0", bus.run_en, bus.ack, bus.pc_load); end
        n_cmp++; if (bus.cycle_count !== 16'd0 || bus.run_count !== 8'd0 || bus.pc_load_value !== 32'd0) begin n_bad++; $display("FAIL async_rst_data count=%0d runs=%0d pcv=%0d want 0/0/0", bus.cycle_count, bus.run_count, bus.pc_load_value); end
        step(1);
        reset_n = 1'b1;
        step(2);
        n_cmp++; if (bus.run_en !== 1'b0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle run_en=%b timeout=%b want 0/0", bus.run_en, bus.timeout); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_launch();
        test_halt();
        test_watchdog();
        test_halt_vs_wdog_and_abort();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
